// File: rtl/german_rule_sched.sv
// Round-robin Murphi rule scheduler for the 3-node German coherence model.
// Picks one enabled rule per cycle, with directed forcing, pause and deadlock detection.
module german_rule_sched #(
    parameter int NUM_RULES   = 24,
    parameter int IDX_W       = 5,
    parameter int STALL_LIMIT = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_RULES-1:0] io_guard,
    input  logic                 io_pause,
    input  logic                 io_force_valid,
    input  logic [IDX_W-1:0]     io_force_rule,
    input  logic                 io_clear,
    output logic                 io_force_ready,
    output logic [IDX_W-1:0]     io_en_a,
    output logic                 io_en_valid,
    output logic                 io_force_err,
    output logic                 io_deadlock,
    output logic [15:0]          io_fire_cnt
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_PAUSE    = 2'd1,
        ST_DEADLOCK = 2'd2
    } state_t;

    localparam int               GUARD_EXT     = 1 << IDX_W;
    localparam logic [IDX_W:0]   NUM_RULES_W   = (IDX_W+1)'(NUM_RULES);
    localparam logic [IDX_W-1:0] LAST_IDX      = IDX_W'(NUM_RULES - 1);
    localparam logic [7:0]       STALL_LIMIT_W = 8'(STALL_LIMIT);

    state_t                 state_r;
    logic [IDX_W-1:0]       ptr_r;
    logic [7:0]             stall_r;

    logic                   active_s;
    logic                   guard_any_s;
    logic [GUARD_EXT-1:0]   guard_ext_s;
    logic                   force_ok_s;
    logic [IDX_W:0]         rr_cand_s;
    logic [IDX_W-1:0]       rr_idx_s;
    logic                   grant_s;
    logic [IDX_W-1:0]       grant_idx_s;
    logic [IDX_W-1:0]       ptr_next_s;
    logic                   force_err_s;
    logic [7:0]             stall_next_s;
    logic                   hit_limit_s;

    assign active_s       = (state_r == ST_RUN) && !io_pause;
    assign io_force_ready = active_s;
    assign guard_any_s    = |io_guard;

    // Zero-extend the guard vector so any force index, even out of range, is a safe lookup.
    always_comb begin
        guard_ext_s                = '0;
        guard_ext_s[NUM_RULES-1:0] = io_guard;
    end

    assign force_ok_s = io_force_valid
                        && ({1'b0, io_force_rule} < NUM_RULES_W)
                        && guard_ext_s[io_force_rule];

    // Round-robin scan: walk downward so the set bit closest to ptr wins last.
    always_comb begin
        rr_idx_s  = '0;
        rr_cand_s = '0;
        for (int i = NUM_RULES - 1; i >= 0; i--) begin
            rr_cand_s = {1'b0, ptr_r} + (IDX_W+1)'(i);
            rr_cand_s = (rr_cand_s >= NUM_RULES_W) ? (rr_cand_s - NUM_RULES_W) : rr_cand_s;
            rr_idx_s  = guard_ext_s[rr_cand_s[IDX_W-1:0]] ? rr_cand_s[IDX_W-1:0] : rr_idx_s;
        end
    end

    // Grant arbitration: a valid force pre-empts round-robin, a bad one blocks it.
    always_comb begin
        grant_s     = 1'b0;
        grant_idx_s = '1;
        ptr_next_s  = ptr_r;
        force_err_s = 1'b0;
        if (active_s && io_force_valid) begin
            if (force_ok_s) begin
                grant_s     = 1'b1;
                grant_idx_s = io_force_rule;
            end else begin
                force_err_s = 1'b1;
            end
        end else if (active_s && guard_any_s) begin
            grant_s     = 1'b1;
            grant_idx_s = rr_idx_s;
            ptr_next_s  = (rr_idx_s == LAST_IDX) ? '0 : (rr_idx_s + IDX_W'(1));
        end else begin
            grant_s = 1'b0;
        end
    end

    // Stall counter moves only while actively scheduling; it freezes in PAUSE and DEADLOCK.
    always_comb begin
        stall_next_s = stall_r;
        if (!active_s) begin
            stall_next_s = stall_r;
        end else if (guard_any_s) begin
            stall_next_s = 8'd0;
        end else if (stall_r != 8'hFF) begin
            stall_next_s = stall_r + 8'd1;
        end else begin
            stall_next_s = stall_r;
        end
    end

    assign hit_limit_s = active_s && !guard_any_s && (stall_next_s == STALL_LIMIT_W);

    // Scheduler FSM with all registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_RUN;
            ptr_r        <= '0;
            stall_r      <= 8'd0;
            io_en_a      <= '1;
            io_en_valid  <= 1'b0;
            io_force_err <= 1'b0;
            io_deadlock  <= 1'b0;
            io_fire_cnt  <= 16'd0;
        end else if (io_clear) begin
            state_r      <= ST_RUN;
            stall_r      <= 8'd0;
            io_en_a      <= '1;
            io_en_valid  <= 1'b0;
            io_force_err <= 1'b0;
            io_deadlock  <= 1'b0;
            io_fire_cnt  <= 16'd0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (hit_limit_s) begin
                        state_r     <= ST_DEADLOCK;
                        io_deadlock <= 1'b1;
                    end else if (io_pause) begin
                        state_r <= ST_PAUSE;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_PAUSE: begin
                    state_r <= io_pause ? ST_PAUSE : ST_RUN;
                end
                ST_DEADLOCK: begin
                    state_r <= ST_DEADLOCK;
                end
                default: begin
                    state_r <= ST_RUN;
                end
            endcase
            stall_r      <= stall_next_s;
            ptr_r        <= ptr_next_s;
            io_en_a      <= grant_idx_s;
            io_en_valid  <= grant_s;
            io_force_err <= force_err_s;
            io_fire_cnt  <= grant_s ? (io_fire_cnt + 16'd1) : io_fire_cnt;
        end
    end

endmodule

// File: tb/tb_german_rule_sched.sv
// Directed bench for german_rule_sched: round-robin, wrap, force, pause, deadlock, async reset.
module tb_german_rule_sched;

    logic        clock;
    logic        reset;
    logic [23:0] io_guard;
    logic        io_pause;
    logic        io_force_valid;
    logic [4:0]  io_force_rule;
    logic        io_clear;
    logic        io_force_ready;
    logic [4:0]  io_en_a;
    logic        io_en_valid;
    logic        io_force_err;
    logic        io_deadlock;
    logic [15:0] io_fire_cnt;

    int n_checks = 0;
    int n_errors = 0;

    german_rule_sched #(
        .NUM_RULES  (24),
        .IDX_W      (5),
        .STALL_LIMIT(16)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .io_guard      (io_guard),
        .io_pause      (io_pause),
        .io_force_valid(io_force_valid),
        .io_force_rule (io_force_rule),
        .io_clear      (io_clear),
        .io_force_ready(io_force_ready),
        .io_en_a       (io_en_a),
        .io_en_valid   (io_en_valid),
        .io_force_err  (io_force_err),
        .io_deadlock   (io_deadlock),
        .io_fire_cnt   (io_fire_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic exp_grant(input string tag, input logic [4:0] idx, input logic vld);
        chk({tag, "_en_a"}, 32'(io_en_a), 32'(idx));
        chk({tag, "_valid"}, 32'(io_en_valid), 32'(vld));
    endtask

    initial begin
        reset          = 1'b1;
        io_guard       = 24'h0;
        io_pause       = 1'b0;
        io_force_valid = 1'b0;
        io_force_rule  = 5'd0;
        io_clear       = 1'b0;
        #2 reset = 1'b0;
        tick();
        tick();
        exp_grant("reset", 5'h1F, 1'b0);
        chk("reset_err", 32'(io_force_err), 32'd0);
        chk("reset_dl", 32'(io_deadlock), 32'd0);
        chk("reset_fire", 32'(io_fire_cnt), 32'd0);
        reset = 1'b1;

        // Round-robin over bits 0 and 2
        io_guard = 24'h000005;
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_grant("rr", (i % 2 == 1) ? 5'd2 : 5'd0, 1'b1);
        end
        chk("rr_fire", 32'(io_fire_cnt), 32'd4);

        // Fresh reset so ptr starts at 0, then wrap through the top index
        #2 reset = 1'b0;
        #1 reset = 1'b1;
        io_guard = 24'h800002;
        tick(); exp_grant("wrap0", 5'd1, 1'b1);
        tick(); exp_grant("wrap1", 5'd23, 1'b1);
        io_guard = 24'h800003;
        tick(); exp_grant("wrap2", 5'd0, 1'b1);
        io_guard = 24'h800002;
        tick(); exp_grant("wrap3", 5'd1, 1'b1);
        chk("wrap_fire", 32'(io_fire_cnt), 32'd4);

        // Directed force; ptr stays at 2 so the next scan picks 3
        io_force_valid = 1'b1;
        io_force_rule  = 5'd5;
        io_guard       = 24'h000028;
        #1 chk("force_ready", 32'(io_force_ready), 32'd1);
        tick(); exp_grant("force5", 5'd5, 1'b1);
        chk("force5_err", 32'(io_force_err), 32'd0);
        io_force_valid = 1'b0;
        tick(); exp_grant("post_force", 5'd3, 1'b1);
        io_force_valid = 1'b1;
        io_force_rule  = 5'd30;
        tick(); exp_grant("force30", 5'h1F, 1'b0);
        chk("force30_err", 32'(io_force_err), 32'd1);
        io_force_rule = 5'd4;
        tick(); exp_grant("force4", 5'h1F, 1'b0);
        chk("force4_err", 32'(io_force_err), 32'd1);
        io_force_valid = 1'b0;
        io_guard       = 24'h0;
        tick(); exp_grant("force_idle", 5'h1F, 1'b0);
        chk("force_err_pulse", 32'(io_force_err), 32'd0);
        chk("force_fire", 32'(io_fire_cnt), 32'd6);

        // Pause with guards set and a force pending; ptr is 4
        io_guard       = 24'h000028;
        io_pause       = 1'b1;
        io_force_valid = 1'b1;
        io_force_rule  = 5'd5;
        #1 chk("pause_ready0", 32'(io_force_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_grant("pause", 5'h1F, 1'b0);
            chk("pause_err", 32'(io_force_err), 32'd0);
            chk("pause_ready", 32'(io_force_ready), 32'd0);
        end
        io_pause       = 1'b0;
        io_force_valid = 1'b0;
        tick(); exp_grant("resume_gap", 5'h1F, 1'b0);
        tick(); exp_grant("resume0", 5'd5, 1'b1);
        tick(); exp_grant("resume1", 5'd3, 1'b1);
        chk("resume_fire", 32'(io_fire_cnt), 32'd8);

        // Stall counter must hold across a pause
        io_guard = 24'h0;
        repeat (10) tick();
        chk("stall10_dl", 32'(io_deadlock), 32'd0);
        io_pause = 1'b1;
        repeat (3) tick();
        io_pause = 1'b0;
        tick();
        repeat (5) tick();
        chk("stall15_dl", 32'(io_deadlock), 32'd0);
        tick();
        chk("stall16_dl", 32'(io_deadlock), 32'd1);
        exp_grant("dl_entry", 5'h1F, 1'b0);

        // Guards ignored in DEADLOCK
        io_guard = 24'h000028;
        #1 chk("dl_ready", 32'(io_force_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_grant("dl_hold", 5'h1F, 1'b0);
            chk("dl_sticky", 32'(io_deadlock), 32'd1);
        end
        chk("dl_fire", 32'(io_fire_cnt), 32'd8);

        // Clear beats a simultaneous force
        io_clear       = 1'b1;
        io_force_valid = 1'b1;
        io_force_rule  = 5'd5;
        tick();
        exp_grant("clear", 5'h1F, 1'b0);
        chk("clear_dl", 32'(io_deadlock), 32'd0);
        chk("clear_fire", 32'(io_fire_cnt), 32'd0);
        chk("clear_err", 32'(io_force_err), 32'd0);
        io_clear       = 1'b0;
        io_force_valid = 1'b0;
        tick(); exp_grant("after_clear", 5'd5, 1'b1);
        chk("after_clear_fire", 32'(io_fire_cnt), 32'd1);

        // Plain 16-cycle deadlock
        io_guard = 24'h0;
        repeat (15) tick();
        chk("plain15_dl", 32'(io_deadlock), 32'd0);
        tick();
        chk("plain16_dl", 32'(io_deadlock), 32'd1);
        io_clear = 1'b1;
        tick();
        io_clear = 1'b0;

        // Async reset while a grant is showing; ptr is 6 beforehand
        io_guard = 24'h000020;
        tick(); exp_grant("pre_reset", 5'd5, 1'b1);
        #2 reset = 1'b0;
        #1 exp_grant("async_reset", 5'h1F, 1'b0);
        chk("async_reset_fire", 32'(io_fire_cnt), 32'd0);
        reset    = 1'b1;
        io_guard = 24'h100008;
        tick(); exp_grant("post_reset", 5'd3, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
